memory_arbiter: RTL and testbench
=================================

// Module: memory_arbiter
// PURPOSE
//  Arbitrates instruction-cache and data-cache miss/writeback traffic onto one single-port RAM.
//  It sits directly downstream of the icache/dcache pair, on the cache side of caches_if,
//  and upstream of the RAM model.
//  One word transfer per grant; the requesting cache holds its request until its wait drops.
// PARAMETERS
//  ADDR_W  32  byte-address width
//  DATA_W  32  word width
// PORTS
//  CLK       in   1       clock, rising edge
//  nRST      in   1       asynchronous reset, active-low
//  iREN      in   1       icache read request
//  iaddr     in   ADDR_W  icache word address
//  iwait     out  1       0 = icache transfer complete this cycle
//  iload     out  DATA_W  icache read data, valid when iwait==0
//  dREN      in   1       dcache read request
//  dWEN      in   1       dcache write request
//  daddr     in   ADDR_W  dcache word address
//  dstore    in   DATA_W  dcache write data
//  dwait     out  1       0 = dcache transfer complete this cycle
//  dload     out  DATA_W  dcache read data, valid when dwait==0
//  ramREN    out  1       RAM read strobe
//  ramWEN    out  1       RAM write strobe
//  ramaddr   out  ADDR_W  RAM address
//  ramstore  out  DATA_W  RAM write data
//  ramload   in   DATA_W  RAM read data, valid with ram_ready
//  ram_ready in   1       RAM access complete; any latency >= 1 cycle
// BEHAVIOUR
//  Reset (async):
//   - state=IDLE, last_grant=I, iwait=dwait=1
//   - iload=dload=0, ramREN=ramWEN=0, ramaddr=ramstore=0
//  FSM states:
//   - IDLE: if any request is present, latch source, op, addr and store data; go to ACCESS.
//   - ACCESS: drive ramREN/ramWEN, ramaddr and ramstore from the latched registers only.
//     On ram_ready: register ramload into the source's load register, deassert ram strobes, go to DONE.
//   - DONE: drop the granted cache's wait to 0 for exactly 1 cycle; go to IDLE.
//  Arbitration in IDLE:
//   - single requester: grant it.
//   - both requesting: grant the side != last_grant.
//   - last_grant resets to I, so dcache wins the first tie; grants alternate under contention.
//   - last_grant updates on entry to ACCESS.
//  Request decode:
//   - dREN&dWEN together is treated as a write.
//   - iREN alone is a read.
//  Latency: request seen in IDLE at cycle t; ram strobes at t+1.
//   - ram_ready at t+k (k>=1) gives wait=0 at t+k+1.
//   - the cache may deassert or change its request the cycle after its wait drops.
//  Boundaries:
//   - Request withdrawn during ACCESS: the RAM access still completes (no torn write) and the DONE pulse still issues.
//   - Address/data change during ACCESS: ignored, because latched values are used.
//   - ram_ready outside ACCESS: ignored.
//   - The non-granted wait stays 1 throughout ACCESS and DONE.
//   - Reset mid-ACCESS: return to reset values immediately; the RAM strobes drop asynchronously.
//   - iload/dload hold their last value when not refreshed.
// CONFIGURATION
//  MEMORY_ARBITER_STATS_EN defined, adds outputs:
//   - icount[31:0], dcount[31:0]: increment on each DONE for that source.
//   - conflicts[31:0]: increments in IDLE when both caches request.
//   - All three reset to 0 and wrap at 2^32.
//  MEMORY_ARBITER_STATS_EN undefined: these ports and counters do not exist; all other behaviour is identical.
// TESTING
//  - iREN=1, iaddr=0x40, RAM ready after 3 cycles with 0xDEADBEEF -> ramREN 1 cycle after request; iwait=0 for 1 cycle with iload=0xDEADBEEF; dwait stays 1.
//  - dWEN=1, daddr=0x80, dstore=0x12345678 -> ramWEN=1, ramaddr=0x80, ramstore=0x12345678 until ram_ready; then dwait=0 for 1 cycle; ramREN never set.
//  - iREN and dREN both held from reset -> grant order D,I,D,I; each wait drops exactly once per grant.
//  - dWEN=1 then daddr changed and dWEN dropped mid-ACCESS -> RAM sees the original address/data; dwait still pulses 0 once.
//  - nRST asserted during ACCESS -> ramREN/ramWEN=0 immediately; after release the FSM is in IDLE and the next tie grants dcache.
//  - STATS_EN build, 3 dcache and 2 icache transfers with 1 tie -> dcount=3, icount=2, conflicts=1.

Source files
------------

// File: rtl/memory_arbiter.sv
// Arbitrates icache/dcache word transfers onto one single-port RAM; one word per grant, alternating on ties.
// Define MEMORY_ARBITER_STATS_EN to add the icount/dcount/conflicts transfer counters.
module memory_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ram_ready
`ifdef MEMORY_ARBITER_STATS_EN
  ,
  output logic [31:0]       icount,
  output logic [31:0]       dcount,
  output logic [31:0]       conflicts
`endif
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  typedef struct packed {
    logic              src_d;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  state_t state, state_nxt;
  req_t   req_q;
  logic   last_d;   // 1 = previous grant went to dcache
  logic   dreq;
  logic   grant_d;
  logic   take;

  assign dreq = dREN | dWEN;

  always_comb begin
    state_nxt = state;
    grant_d   = 1'b0;
    take      = 1'b0;
    case (state)
      IDLE: if (iREN | dreq) begin
        take      = 1'b1;
        // lone dcache wins outright; on a tie the side not granted last time wins
        grant_d   = dreq & (~iREN | ~last_d);
        state_nxt = ACCESS;
      end
      ACCESS: if (ram_ready) state_nxt = DONE;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      req_q  <= '0;
      last_d <= 1'b0;
      iload  <= '0;
      dload  <= '0;
    end else begin
      state <= state_nxt;
      if (take) begin
        req_q.src_d <= grant_d;
        req_q.wr    <= grant_d & dWEN;
        req_q.addr  <= grant_d ? daddr : iaddr;
        req_q.data  <= grant_d ? dstore : '0;
        last_d      <= grant_d;
      end
      if (state == ACCESS && ram_ready) begin
        if (req_q.src_d) dload <= ramload;
        else             iload <= ramload;
      end
    end
  end

  // RAM side comes only from latched request so mid-access input changes cannot tear a transfer
  assign ramREN   = (state == ACCESS) & ~req_q.wr;
  assign ramWEN   = (state == ACCESS) &  req_q.wr;
  assign ramaddr  = req_q.addr;
  assign ramstore = req_q.data;
  assign iwait    = ~((state == DONE) & ~req_q.src_d);
  assign dwait    = ~((state == DONE) &  req_q.src_d);

`ifdef MEMORY_ARBITER_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      icount    <= '0;
      dcount    <= '0;
      conflicts <= '0;
    end else begin
      if (state == DONE) begin
        if (req_q.src_d) dcount <= dcount + 32'd1;
        else             icount <= icount + 32'd1;
      end
      if (state == IDLE && iREN && dreq) conflicts <= conflicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: a latency-programmable RAM model plus a wait-pulse monitor.
module tb_memory_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          iREN = 1'b0;
  logic [AW-1:0] iaddr = '0;
  logic          iwait;
  logic [DW-1:0] iload;
  logic          dREN = 1'b0;
  logic          dWEN = 1'b0;
  logic [AW-1:0] daddr = '0;
  logic [DW-1:0] dstore = '0;
  logic          dwait;
  logic [DW-1:0] dload;
  logic          ramREN;
  logic          ramWEN;
  logic [AW-1:0] ramaddr;
  logic [DW-1:0] ramstore;
  logic [DW-1:0] ramload = '0;
  logic          ram_ready = 1'b0;
`ifdef MEMORY_ARBITER_STATS_EN
  logic [31:0]   icount, dcount, conflicts;
`endif

  memory_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready)
`ifdef MEMORY_ARBITER_STATS_EN
    , .icount(icount), .dcount(dcount), .conflicts(conflicts)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct { bit d; bit chk; logic [DW-1:0] load; } exp_t;
  typedef struct { bit d; logic [DW-1:0] load; int c; } obs_t;
  exp_t exp_q[$];
  obs_t obs_q[$];

  int n_cmp = 0, n_err = 0;
  int cyc = 0, ip = 0, dp = 0, both_low = 0, ren_cyc = 0;

  // RAM model: ready asserted `lat` strobe cycles after the access starts
  int            lat = 1;
  bit            addr_mode = 1'b0;
  logic [DW-1:0] rdata = '0;
  int            rcnt = 0;
  logic [AW-1:0] seen_addr = '0;
  logic [DW-1:0] seen_data = '0;
  bit            seen_wr = 1'b0;

  always @(posedge CLK) cyc++;

  always @(negedge CLK) begin
    if (ram_ready) begin
      ram_ready = 1'b0;
      rcnt = 0;
    end else if (ramREN || ramWEN) begin
      rcnt++;
      if (rcnt >= lat) begin
        ram_ready = 1'b1;
        ramload   = addr_mode ? ramaddr + 32'h1000 : rdata;
        seen_addr = ramaddr;
        seen_data = ramstore;
        seen_wr   = ramWEN;
      end
    end else rcnt = 0;
  end

  always @(negedge CLK) begin
    if (!iwait) begin ip++; obs_q.push_back('{1'b0, iload, cyc}); end
    if (!dwait) begin dp++; obs_q.push_back('{1'b1, dload, cyc}); end
    if (!iwait && !dwait) both_low++;
    if (ramREN) ren_cyc++;
  end

  task automatic wait_obs(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge CLK); #1;
      if (obs_q.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    n_cmp++; if ({iwait, dwait, ramREN, ramWEN} !== 4'b1100) begin n_err++;
      $display("FAIL reset_ctl: got %b want 1100", {iwait, dwait, ramREN, ramWEN}); end
    n_cmp++; if ({ramaddr, ramstore} !== 64'h0) begin n_err++;
      $display("FAIL reset_ram: got %h/%h want 0/0", ramaddr, ramstore); end
    n_cmp++; if ({iload, dload} !== 64'h0) begin n_err++;
      $display("FAIL reset_load: got %h/%h want 0/0", iload, dload); end
    @(negedge CLK); nRST = 1'b1;
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_iread;
    int c0, ip0, dp0; bit ok; obs_t o; exp_t e;
    obs_q.delete(); exp_q.delete();
    lat = 3; addr_mode = 1'b0; rdata = 32'hDEADBEEF; ip0 = ip; dp0 = dp;
    @(posedge CLK); #1;
    iREN = 1'b1; iaddr = 32'h40; c0 = cyc;
    exp_q.push_back('{1'b0, 1'b1, 32'hDEADBEEF});
    @(posedge CLK); @(negedge CLK);
    n_cmp++; if ({ramREN, ramWEN} !== 2'b10 || ramaddr !== 32'h40) begin n_err++;
      $display("FAIL iread_strobe: got ren/wen=%b addr=%h want 10 addr=40", {ramREN, ramWEN}, ramaddr); end
    wait_obs(1, ok);
    @(posedge CLK); #1; iREN = 1'b0;
    n_cmp++; if (!ok) begin n_err++; $display("FAIL iread_timeout: got no wait pulse want one"); end
    if (ok) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_cmp++; if (o.d !== e.d || o.load !== e.load) begin n_err++;
        $display("FAIL iread_data: got src=%0d load=%h want src=%0d load=%h", o.d, o.load, e.d, e.load); end
      n_cmp++; if (o.c - c0 !== 4) begin n_err++;
        $display("FAIL iread_latency: got %0d want 4", o.c - c0); end
    end
    repeat (4) @(posedge CLK); #1;
    n_cmp++; if (ip - ip0 !== 1 || dp - dp0 !== 0) begin n_err++;
      $display("FAIL iread_pulses: got i=%0d d=%0d want i=1 d=0", ip - ip0, dp - dp0); end
  endtask

  task automatic test_dwrite;
    int c0, dp0, ren0; bit ok; obs_t o; exp_t e;
    obs_q.delete(); exp_q.delete();
    lat = 2; addr_mode = 1'b0; rdata = 32'h0BAD0BAD; dp0 = dp; ren0 = ren_cyc;
    @(posedge CLK); #1;
    dWEN = 1'b1; daddr = 32'h80; dstore = 32'h12345678; c0 = cyc;
    exp_q.push_back('{1'b1, 1'b0, 32'h0});
    @(posedge CLK);
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      n_cmp++; if ({ramREN, ramWEN} !== 2'b01 || ramaddr !== 32'h80 || ramstore !== 32'h12345678) begin n_err++;
        $display("FAIL dwrite_bus%0d: got ren/wen=%b addr=%h data=%h want 01 80 12345678", k, {ramREN, ramWEN}, ramaddr, ramstore); end
    end
    wait_obs(1, ok);
    @(posedge CLK); #1; dWEN = 1'b0;
    n_cmp++; if (!ok) begin n_err++; $display("FAIL dwrite_timeout: got no wait pulse want one"); end
    if (ok) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_cmp++; if (o.d !== e.d || o.c - c0 !== 3) begin n_err++;
        $display("FAIL dwrite_done: got src=%0d lat=%0d want src=%0d lat=3", o.d, o.c - c0, e.d); end
    end
    repeat (4) @(posedge CLK); #1;
    n_cmp++; if (seen_wr !== 1'b1 || seen_addr !== 32'h80 || seen_data !== 32'h12345678) begin n_err++;
      $display("FAIL dwrite_ram: got wr=%0d addr=%h data=%h want 1 80 12345678", seen_wr, seen_addr, seen_data); end
    n_cmp++; if (ren_cyc !== ren0 || dp - dp0 !== 1) begin n_err++;
      $display("FAIL dwrite_side: got ren_cycles=%0d pulses=%0d want 0 1", ren_cyc - ren0, dp - dp0); end
    n_cmp++; if (iload !== 32'hDEADBEEF) begin n_err++;
      $display("FAIL iload_hold: got %h want deadbeef", iload); end
  endtask

  task automatic test_back_to_back;
    int ip0, dp0, bl0; bit ok; obs_t o; exp_t e;
    nRST = 1'b0; iREN = 1'b1; dREN = 1'b1; iaddr = 32'h100; daddr = 32'h200;
    addr_mode = 1'b1; lat = 1;
    repeat (2) @(posedge CLK);
    @(negedge CLK); nRST = 1'b1;
    obs_q.delete(); exp_q.delete();
    ip0 = ip; dp0 = dp; bl0 = both_low;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back('{1'b1, 1'b1, 32'h1200});
      exp_q.push_back('{1'b0, 1'b1, 32'h1100});
    end
    wait_obs(4, ok);
    @(posedge CLK); #1; iREN = 1'b0; dREN = 1'b0;
    n_cmp++; if (!ok) begin n_err++; $display("FAIL tie_timeout: got %0d pulses want 4", obs_q.size()); end
    for (int k = 0; k < 4; k++) begin
      if (obs_q.size() > 0 && exp_q.size() > 0) begin
        o = obs_q.pop_front(); e = exp_q.pop_front();
        n_cmp++; if (o.d !== e.d || o.load !== e.load) begin n_err++;
          $display("FAIL tie_grant%0d: got src=%0d load=%h want src=%0d load=%h", k, o.d, o.load, e.d, e.load); end
      end
    end
    repeat (5) @(posedge CLK); #1;
    n_cmp++; if (ip - ip0 !== 2 || dp - dp0 !== 2 || both_low !== bl0) begin n_err++;
      $display("FAIL tie_pulses: got i=%0d d=%0d both=%0d want 2 2 0", ip - ip0, dp - dp0, both_low - bl0); end
  endtask

  task automatic test_withdraw;
    int dp0; bit ok;
    obs_q.delete(); exp_q.delete();
    lat = 4; addr_mode = 1'b0; rdata = '0; dp0 = dp;
    @(posedge CLK); #1;
    dWEN = 1'b1; daddr = 32'h300; dstore = 32'hCAFEF00D;
    @(posedge CLK); @(posedge CLK); #1;
    dWEN = 1'b0; daddr = 32'h999; dstore = 32'h0;
    wait_obs(1, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL withdraw_timeout: got no wait pulse want one"); end
    repeat (5) @(posedge CLK); #1;
    n_cmp++; if (seen_wr !== 1'b1 || seen_addr !== 32'h300 || seen_data !== 32'hCAFEF00D) begin n_err++;
      $display("FAIL withdraw_ram: got wr=%0d addr=%h data=%h want 1 300 cafef00d", seen_wr, seen_addr, seen_data); end
    n_cmp++; if (dp - dp0 !== 1) begin n_err++;
      $display("FAIL withdraw_pulses: got %0d want 1", dp - dp0); end
  endtask

  task automatic test_reset_mid;
    bit ok; obs_t o; exp_t e;
    obs_q.delete(); exp_q.delete();
    lat = 10; addr_mode = 1'b0;
    @(posedge CLK); #1;
    iREN = 1'b1; iaddr = 32'h44;
    @(posedge CLK); @(negedge CLK);
    n_cmp++; if (ramREN !== 1'b1) begin n_err++; $display("FAIL rmid_pre: got ramREN=%b want 1", ramREN); end
    #1 nRST = 1'b0;
    #1;
    n_cmp++; if ({ramREN, ramWEN, iwait, dwait} !== 4'b0011 || ramaddr !== 32'h0) begin n_err++;
      $display("FAIL rmid_async: got ctl=%b addr=%h want 0011 0", {ramREN, ramWEN, iwait, dwait}, ramaddr); end
    iREN = 1'b0;
    @(posedge CLK); @(negedge CLK);
    nRST = 1'b1;
    obs_q.delete(); exp_q.delete();
    lat = 1; addr_mode = 1'b1; iaddr = 32'h10; daddr = 32'h20; iREN = 1'b1; dREN = 1'b1;
    exp_q.push_back('{1'b1, 1'b1, 32'h1020});
    wait_obs(1, ok);
    @(posedge CLK); #1; iREN = 1'b0; dREN = 1'b0;
    n_cmp++; if (!ok) begin n_err++; $display("FAIL rmid_timeout: got no wait pulse want one"); end
    if (ok) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_cmp++; if (o.d !== e.d || o.load !== e.load) begin n_err++;
        $display("FAIL rmid_tie: got src=%0d load=%h want src=%0d load=%h", o.d, o.load, e.d, e.load); end
    end
    repeat (4) @(posedge CLK);
  endtask

`ifdef MEMORY_ARBITER_STATS_EN
  task automatic test_stats;
    bit ok; int n;
    nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK); nRST = 1'b1;
    obs_q.delete(); exp_q.delete();
    n_cmp++; if ({icount, dcount, conflicts} !== 96'h0) begin n_err++;
      $display("FAIL stats_reset: got %0d/%0d/%0d want 0/0/0", icount, dcount, conflicts); end
    lat = 2; addr_mode = 1'b1;
    iREN = 1'b1; iaddr = 32'h10; dREN = 1'b1; daddr = 32'h20;
    wait_obs(1, ok);
    @(posedge CLK); #1; dREN = 1'b0;
    wait_obs(2, ok);
    @(posedge CLK); #1; iREN = 1'b0;
    n = 2;
    for (int k = 0; k < 3; k++) begin
      if (k < 2) begin dWEN = 1'b1; daddr = 32'h40 + k; dstore = k; end
      else begin iREN = 1'b1; iaddr = 32'h60; end
      n++;
      wait_obs(n, ok);
      @(posedge CLK); #1; dWEN = 1'b0; iREN = 1'b0;
    end
    repeat (3) @(posedge CLK); #1;
    n_cmp++; if (dcount !== 32'd3 || icount !== 32'd2 || conflicts !== 32'd1) begin n_err++;
      $display("FAIL stats_counts: got d=%0d i=%0d c=%0d want 3 2 1", dcount, icount, conflicts); end
  endtask
`endif

  initial begin
    test_reset;
    test_iread;
    test_dwrite;
    test_back_to_back;
    test_withdraw;
    test_reset_mid;
`ifdef MEMORY_ARBITER_STATS_EN
    test_stats;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want finish before 200000");
    $fatal(1);
  end

endmodule
